// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes, RV32I opcodes, the 5-bit ALU opcode set and writeback selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BR    = 3'd4,
    CLS_LUI   = 3'd5,
    CLS_JAL   = 3'd6,
    CLS_ILL   = 3'd7
  } ins_class_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_AND   = 5'b00001;
  localparam logic [4:0] ALU_OR    = 5'b00010;
  localparam logic [4:0] ALU_XOR   = 5'b00011;
  localparam logic [4:0] ALU_SLL   = 5'b00100;
  localparam logic [4:0] ALU_SRL   = 5'b00101;
  localparam logic [4:0] ALU_SRA   = 5'b00110;
  localparam logic [4:0] ALU_SUB   = 5'b00111;
  localparam logic [4:0] ALU_LOAD  = 5'b01000;
  localparam logic [4:0] ALU_BEQ   = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_STORE = 5'b10100;
  localparam logic [4:0] ALU_SLTU  = 5'b10101;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_LUI = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  // ALU opcode for register/immediate arithmetic; only R-type may select sub.
  function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic is_r);
    logic [4:0] op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface mc_ctrl_if;
  logic        run;
  logic [31:0] ins;
  logic        con;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic        mem_we;
  logic [4:0]  alu_op;
  logic        alu_srcb;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [31:0] instret;

  modport master (
    input  run, ins, con,
    output ir_we, pc_we, pc_sel, rf_we, mem_we, alu_op, alu_srcb, wb_sel,
           halted, instret
  );

  modport slave (
    output run, ins, con,
    input  ir_we, pc_we, pc_sel, rf_we, mem_we, alu_op, alu_srcb, wb_sel,
           halted, instret
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies the instruction word and
// derives the ALU opcode and operand-B select. Results are latched by mc_ctrl.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] ins,
  output ins_class_e  cls,
  output logic [4:0]  alu_op,
  output logic        alu_srcb
);

  logic unused_ins_s;
  assign unused_ins_s = ^{ins[31], ins[29:15], ins[11:7]};

  // Opcode -> class, funct3/ins[30] -> ALU opcode.
  always_comb begin
    cls      = CLS_ILL;
    alu_op   = ALU_ADD;
    alu_srcb = 1'b0;
    case (ins[6:0])
      OPC_R: begin
        cls    = CLS_R;
        alu_op = arith_op(ins[14:12], ins[30], 1'b1);
      end
      OPC_I: begin
        cls      = CLS_I;
        alu_op   = arith_op(ins[14:12], ins[30], 1'b0);
        alu_srcb = 1'b1;
      end
      OPC_LOAD: begin
        cls      = CLS_LOAD;
        alu_op   = ALU_LOAD;
        alu_srcb = 1'b1;
      end
      OPC_STORE: begin
        cls      = CLS_STORE;
        alu_op   = ALU_STORE;
        alu_srcb = 1'b1;
      end
      OPC_BR: begin
        case (ins[14:12])
          3'b000, 3'b001: begin cls = CLS_BR; alu_op = ALU_BEQ;  end
          3'b100, 3'b101: begin cls = CLS_BR; alu_op = ALU_SLT;  end
          3'b110, 3'b111: begin cls = CLS_BR; alu_op = ALU_SLTU; end
          default:        begin cls = CLS_ILL; alu_op = ALU_ADD; end
        endcase
      end
      OPC_LUI: cls = CLS_LUI;
      OPC_JAL: cls = CLS_JAL;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: walks the shared datapath through IF/ID/EX/MEM/WB,
// issues one-cycle write strobes and counts retired instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  state_e      state_r;
  ins_class_e  cls_r;
  ins_class_e  dec_cls_s;
  logic [2:0]  f3_r;
  logic [4:0]  alu_op_r;
  logic [4:0]  dec_alu_op_s;
  logic        alu_srcb_r;
  logic        dec_srcb_s;
  logic        pc_we_r;
  logic        pc_sel_r;
  logic        rf_we_r;
  logic        mem_we_r;
  logic        halted_r;
  logic [1:0]  wb_sel_r;
  logic [31:0] instret_r;
  logic        br_taken_s;
  logic        unused_f3_s;

  assign unused_f3_s = ^f3_r[2:1];

  mc_decode u_decode (
    .ins      (bus.ins),
    .cls      (dec_cls_s),
    .alu_op   (dec_alu_op_s),
    .alu_srcb (dec_srcb_s)
  );

  // Control FSM: strobes are set on the edge entering the state that owns them
  // and are cleared by default, so each is exactly one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IF;
      cls_r      <= CLS_R;
      f3_r       <= 3'd0;
      alu_op_r   <= ALU_ADD;
      alu_srcb_r <= 1'b0;
      pc_we_r    <= 1'b0;
      pc_sel_r   <= 1'b0;
      rf_we_r    <= 1'b0;
      mem_we_r   <= 1'b0;
      wb_sel_r   <= WB_ALU;
      halted_r   <= 1'b0;
    end else begin
      pc_we_r  <= 1'b0;
      pc_sel_r <= 1'b0;
      rf_we_r  <= 1'b0;
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IF: begin
          if (bus.run) state_r <= ST_ID;
          else         state_r <= ST_IF;
        end
        ST_ID: begin
          cls_r      <= dec_cls_s;
          f3_r       <= bus.ins[14:12];
          alu_op_r   <= dec_alu_op_s;
          alu_srcb_r <= dec_srcb_s;
          case (dec_cls_s)
            CLS_LUI: begin
              state_r  <= ST_WB;
              rf_we_r  <= 1'b1;
              pc_we_r  <= 1'b1;
              wb_sel_r <= WB_LUI;
            end
            CLS_JAL: begin
              state_r  <= ST_WB;
              rf_we_r  <= 1'b1;
              pc_we_r  <= 1'b1;
              pc_sel_r <= 1'b1;
              wb_sel_r <= WB_PC4;
            end
            CLS_BR: begin
              state_r <= ST_EX;
              pc_we_r <= 1'b1;
            end
            CLS_ILL: begin
              state_r    <= ST_HALT;
              halted_r   <= 1'b1;
              alu_op_r   <= ALU_ADD;
              alu_srcb_r <= 1'b0;
            end
            default: state_r <= ST_EX;
          endcase
        end
        ST_EX: begin
          case (cls_r)
            CLS_R, CLS_I: begin
              state_r  <= ST_WB;
              rf_we_r  <= 1'b1;
              pc_we_r  <= 1'b1;
              wb_sel_r <= WB_ALU;
            end
            CLS_LOAD: state_r <= ST_MEM;
            CLS_STORE: begin
              state_r  <= ST_MEM;
              mem_we_r <= 1'b1;
              pc_we_r  <= 1'b1;
            end
            default: begin
              state_r    <= ST_IF;
              alu_op_r   <= ALU_ADD;
              alu_srcb_r <= 1'b0;
            end
          endcase
        end
        ST_MEM: begin
          if (cls_r == CLS_LOAD) begin
            state_r  <= ST_WB;
            rf_we_r  <= 1'b1;
            pc_we_r  <= 1'b1;
            wb_sel_r <= WB_MEM;
          end else begin
            state_r    <= ST_IF;
            alu_op_r   <= ALU_ADD;
            alu_srcb_r <= 1'b0;
          end
        end
        ST_WB: begin
          state_r    <= ST_IF;
          wb_sel_r   <= WB_ALU;
          alu_op_r   <= ALU_ADD;
          alu_srcb_r <= 1'b0;
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_IF;
      endcase
    end
  end

  // Retired-instruction counter: bumps on the edge that ends each pc_we pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instret_r <= 32'd0;
    else if (pc_we_r) instret_r <= instret_r + 32'd1;
    else              instret_r <= instret_r;
  end

  // The branch decision must be valid at the edge that writes the PC, which is
  // the end of EX; con only settles in EX, so it gates pc_sel in that one state.
  assign br_taken_s = (state_r == ST_EX) && (cls_r == CLS_BR) && (bus.con ^ f3_r[0]);

  assign bus.ir_we    = (state_r == ST_IF) && bus.run;
  assign bus.pc_we    = pc_we_r;
  assign bus.pc_sel   = pc_sel_r | br_taken_s;
  assign bus.rf_we    = rf_we_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.alu_op   = alu_op_r;
  assign bus.alu_srcb = alu_srcb_r;
  assign bus.wb_sel   = wb_sel_r;
  assign bus.halted   = halted_r;
  assign bus.instret  = instret_r;

endmodule
